// File: rtl/popcnt_pkg.sv
// popcnt_pkg: shared state encoding, width limit and SWAR fold-mask helper for popcount_engine.
package popcnt_pkg;
  localparam int MAX_WIDTH = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  // Mask M[k]: alternating runs of 2^k ones and 2^k zeros starting at the LSB
  function automatic logic [MAX_WIDTH-1:0] fold_mask(input int width, input int k);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < width && i < MAX_WIDTH; i++) m[i] = ((i >> k) % 2) == 0;
    return m;
  endfunction
endpackage

// File: rtl/popcnt_fold.sv
// popcnt_fold: one SWAR mask-and-add fold of t_i at the runtime-selected level k_i.
module popcnt_fold
  import popcnt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 3
) (
  input  logic [WIDTH-1:0] t_i,
  input  logic [SW-1:0]    k_i,
  output logic [WIDTH-1:0] f_o
);
  localparam int L = $clog2(WIDTH);
  logic [WIDTH-1:0] lvl [L];
  for (genvar g = 0; g < L; g++) begin : g_lvl
    localparam logic [WIDTH-1:0] M = WIDTH'(fold_mask(WIDTH, g));
    assign lvl[g] = (t_i & M) + ((t_i >> (2 ** g)) & M);
  end
  always_comb begin
    f_o = t_i;
    for (int i = 0; i < L; i++) if (k_i == SW'(i)) f_o = lvl[i];
  end
endmodule

// File: rtl/popcount_engine.sv
// popcount_engine: handshaked popcount / Hamming-distance unit, one SWAR fold level per clock.
// Optional threshold compare (thr / out_ge) is enabled by defining POPCNT_THRESH_EN.
module popcount_engine
  import popcnt_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH) + 1,
  localparam int L  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             mode,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic             out_vld,
  input  logic             out_rdy,
`ifdef POPCNT_THRESH_EN
  input  logic [CW-1:0]    thr,
  output logic [0:0]       out_ge,
`endif
  output logic [CW-1:0]    hw_out
);
  localparam int SW = $clog2(L);
  if (WIDTH < 8 || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("popcount_engine: WIDTH must be a power of two in 8..64");
  end
  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] t_q, t_d, fold;
  logic             last;
  popcnt_fold #(.WIDTH(WIDTH), .SW(SW)) u_fold (.t_i(t_q), .k_i(step_q), .f_o(fold));
  assign last = step_q == SW'(L - 1);
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    t_d     = t_q;
    case (state_q)
      IDLE: if (in_vld) begin
        state_d = BUSY;
        step_d  = '0;
        t_d     = mode ? din_a ^ din_b : din_a;
      end
      BUSY: begin
        t_d     = fold;
        step_d  = last ? '0 : step_q + SW'(1);
        state_d = last ? DONE : BUSY;
      end
      DONE: if (out_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      t_q     <= t_d;
    end
  end
  assign in_rdy  = state_q == IDLE;
  assign out_vld = state_q == DONE;
  assign hw_out  = t_q[CW-1:0];
`ifdef POPCNT_THRESH_EN
  logic [CW-1:0] thr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thr_q <= '0;
    else if (in_rdy && in_vld) thr_q <= thr;
  end
  assign out_ge = out_vld && hw_out >= thr_q;
`endif
endmodule

// File: tb/tb_popcount_engine.sv
// tb_popcount_engine: scoreboard bench for popcount_engine (latency, stall, abort, random sweep).
module tb_popcount_engine;
  localparam int W  = 32;
  localparam int CW = $clog2(W) + 1;
  localparam int L  = $clog2(W);
  logic          clk = 0, rst_n = 0, in_vld = 0, mode = 0, out_rdy = 0;
  logic [W-1:0]  din_a = '0, din_b = '0;
  logic          in_rdy, out_vld;
  logic [CW-1:0] hw_out;
`ifdef POPCNT_THRESH_EN
  logic [CW-1:0] thr = '0;
  logic [0:0]    out_ge;
`endif
  int            checks = 0, errors = 0;
  logic [CW-1:0] exp_q [$];

  always #5 clk = ~clk;

  popcount_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .mode(mode),
    .din_a(din_a), .din_b(din_b), .out_vld(out_vld), .out_rdy(out_rdy),
`ifdef POPCNT_THRESH_EN
    .thr(thr), .out_ge(out_ge),
`endif
    .hw_out(hw_out)
  );

  function automatic logic [CW-1:0] ref_pc(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    return CW'($countones(m ? a ^ b : a));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    mode = m; din_a = a; din_b = b; in_vld = 1;
    while (!in_rdy && n < 100) begin tick(); n++; end
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_rdy=%b required 1", in_rdy);
    end
    exp_q.push_back(ref_pc(m, a, b));
    tick();
    in_vld = 0;
  endtask

  task automatic recv(output int lat);
    logic [CW-1:0] e;
    int n = 0;
    out_rdy = 1;
    while (!out_vld && n < 100) begin tick(); n++; end
    lat = n;
    checks++;
    if (out_vld !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL recv_timeout: out_vld=%b queued=%0d required valid result", out_vld, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (hw_out !== e) begin
        errors++;
        $display("FAIL result: hw_out=%0d required %0d", hw_out, e);
      end
    end
    tick();
    out_rdy = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0 || hw_out !== '0) begin
      errors++;
      $display("FAIL reset: in_rdy=%b out_vld=%b hw_out=%0d required 1 0 0", in_rdy, out_vld, hw_out);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_popcount();
    int lat;
    send(0, '1, '0);
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL busy_rdy: in_rdy=%b required 0", in_rdy);
    end
    recv(lat);
    checks++;
    if (lat != L) begin
      errors++;
      $display("FAIL latency: got %0d clocks required %0d", lat, L);
    end
    send(1, W'(64'hF0F0_1234_A5A5_0F0F), W'(64'h0F0F_1234_5A5A_F0F0));
    recv(lat);
    send(0, '0, '1);
    recv(lat);
    send(0, W'(64'h8000_0000_0000_0001) | (W'(1) << (W - 1)), '1);
    recv(lat);
  endtask

  task automatic test_stall();
    int n = 0, lat;
    logic [CW-1:0] e;
    send(0, W'(64'h0000_00FF_0000_0F0F), '0);
    while (!out_vld && n < 100) begin tick(); n++; end
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    mode = 1; din_a = W'(64'h1234_5678_9ABC_DEF0); din_b = '1; in_vld = 1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_vld !== 1'b1 || hw_out !== e || in_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: out_vld=%b hw_out=%0d in_rdy=%b required 1 %0d 0", out_vld, hw_out, in_rdy, e);
      end
      tick();
    end
    out_rdy = 1;
    tick();
    out_rdy = 0;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: out_vld=%b in_rdy=%b required 0 1", out_vld, in_rdy);
    end
    exp_q.push_back(ref_pc(mode, din_a, din_b));
    tick();
    in_vld = 0;
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: in_rdy=%b required 0", in_rdy);
    end
    recv(lat);
  endtask

  task automatic test_abort();
    int lat;
    logic seen = 0;
    send(0, '1, '0);
    tick(); tick();
    #2 rst_n = 0;
    #1;
    exp_q.delete();
    checks++;
    if (out_vld !== 1'b0 || hw_out !== '0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort: out_vld=%b hw_out=%0d in_rdy=%b required 0 0 1", out_vld, hw_out, in_rdy);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < L + 2; i++) begin tick(); seen |= out_vld; end
    checks++;
    if (seen !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: out_vld_seen=%b in_rdy=%b required 0 1", seen, in_rdy);
    end
    send(0, W'(64'h8000_0000_0000_0001), '0);
    recv(lat);
  endtask

  task automatic test_sweep();
    int lat;
    logic m;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      a = W'({$urandom, $urandom});
      b = W'({$urandom, $urandom});
      send(m, a, b);
      recv(lat);
      checks++;
      if (lat != L) begin
        errors++;
        $display("FAIL sweep_latency: got %0d required %0d", lat, L);
      end
    end
  endtask

`ifdef POPCNT_THRESH_EN
  task automatic test_thresh();
    int lat;
    logic ge_exp;
    for (int j = 0; j < 2; j++) begin
      thr = CW'(W / 2 + j);
      ge_exp = (j == 0);
      send(0, (W'(1) << (W / 2)) - W'(1), '0);
      checks++;
      if (out_ge !== 1'b0) begin
        errors++;
        $display("FAIL ge_idle: out_ge=%b required 0", out_ge);
      end
      for (int n = 0; n < 100 && !out_vld; n++) tick();
      checks++;
      if (out_ge !== ge_exp) begin
        errors++;
        $display("FAIL ge_value: out_ge=%b required %b thr=%0d", out_ge, ge_exp, thr);
      end
      recv(lat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_popcount();
    test_stall();
    test_abort();
    test_sweep();
`ifdef POPCNT_THRESH_EN
    test_thresh();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
